// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer
// Trigger-driven gating of a two-samples-per-clock stream into FFT frames.
// A rising trigger starts a sequence: a programmable delay, then one or more
// frames of FRAME_LEN clocks each. A frame starts only once the FFT core is
// ready, and it always runs to completion once started. All outputs are
// registered, so they follow the accepted samples by one clock.
// Optional feature macro: FRAME_SEQ_TRIG_LOST_CNT_EN adds trig_lost_cnt_o,
// a saturating 16-bit count of ignored triggers.
module fft_frame_sequencer #(
    parameter int FRAME_LEN = 512,
    parameter int DW        = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 trig_i,
    input  logic [15:0]          cfg_delay_i,
    input  logic [7:0]           cfg_frames_i,
    input  logic                 fft_ready_i,
    input  logic signed [DW-1:0] x0_i,
    input  logic signed [DW-1:0] x0z_i,
    output logic signed [DW-1:0] y0_o,
    output logic signed [DW-1:0] y0z_o,
    output logic                 frame_valid_o,
    output logic                 frame_start_o,
    output logic                 frame_last_o,
    output logic [7:0]           frame_idx_o,
    output logic                 busy_o,
    output logic                 done_o,
`ifdef FRAME_SEQ_TRIG_LOST_CNT_EN
    output logic                 trig_lost_o,
    output logic [15:0]          trig_lost_cnt_o
`else
    output logic                 trig_lost_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_WAIT_RDY,
        S_STREAM
    } state_t;

    localparam int            CW       = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0] LAST_SMP = CW'(FRAME_LEN - 1);

    state_t               state_q;
    logic [15:0]          dly_cnt_q;
    logic [CW-1:0]        smp_cnt_q;
    logic [7:0]           frames_q;
    logic [7:0]           idx_q;
    logic                 trig_prev_q;

    logic signed [DW-1:0] y0_q;
    logic signed [DW-1:0] y0z_q;
    logic                 valid_q;
    logic                 start_q;
    logic                 last_q;
    logic [7:0]           idx_out_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 lost_q;

    logic                 trig_edge;

    // The previous-trigger register resets high, so a trigger level held
    // through reset is not mistaken for a fresh edge.
    assign trig_edge = trig_i & ~trig_prev_q;

    // Sequencer FSM together with every registered output.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            dly_cnt_q   <= '0;
            smp_cnt_q   <= '0;
            frames_q    <= '0;
            idx_q       <= '0;
            trig_prev_q <= 1'b1;
            y0_q        <= '0;
            y0z_q       <= '0;
            valid_q     <= 1'b0;
            start_q     <= 1'b0;
            last_q      <= 1'b0;
            idx_out_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            lost_q      <= 1'b0;
        end else begin
            trig_prev_q <= trig_i;

            // Outputs idle unless a sample is being passed this cycle.
            y0_q      <= '0;
            y0z_q     <= '0;
            valid_q   <= 1'b0;
            start_q   <= 1'b0;
            last_q    <= 1'b0;
            idx_out_q <= '0;
            done_q    <= 1'b0;
            lost_q    <= 1'b0;
            busy_q    <= (state_q != S_IDLE);

            case (state_q)
                S_IDLE: begin
                    if (trig_edge) begin
                        // done_q high means the last sample of the previous
                        // sequence is on the outputs right now; a trigger here
                        // is treated as overlapping that sequence.
                        if (done_q) begin
                            lost_q <= 1'b1;
                        end else if (cfg_frames_i != 8'd0) begin
                            dly_cnt_q <= cfg_delay_i;
                            frames_q  <= cfg_frames_i;
                            idx_q     <= '0;
                            state_q   <= S_DELAY;
                        end
                    end
                end

                S_DELAY: begin
                    lost_q <= trig_edge;
                    if (dly_cnt_q == 16'd0) begin
                        state_q <= S_WAIT_RDY;
                    end else begin
                        dly_cnt_q <= dly_cnt_q - 16'd1;
                    end
                end

                S_WAIT_RDY: begin
                    lost_q <= trig_edge;
                    if (fft_ready_i) begin
                        smp_cnt_q <= '0;
                        state_q   <= S_STREAM;
                    end
                end

                S_STREAM: begin
                    lost_q    <= trig_edge;
                    y0_q      <= x0_i;
                    y0z_q     <= x0z_i;
                    valid_q   <= 1'b1;
                    start_q   <= (smp_cnt_q == '0);
                    last_q    <= (smp_cnt_q == LAST_SMP);
                    idx_out_q <= idx_q;
                    if (smp_cnt_q == LAST_SMP) begin
                        smp_cnt_q <= '0;
                        if (idx_q + 8'd1 == frames_q) begin
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            // Ready is only consulted at the frame boundary;
                            // a drop mid-frame never interrupts the frame.
                            idx_q <= idx_q + 8'd1;
                            if (!fft_ready_i) begin
                                state_q <= S_WAIT_RDY;
                            end
                        end
                    end else begin
                        smp_cnt_q <= smp_cnt_q + CW'(1);
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign y0_o          = y0_q;
    assign y0z_o         = y0z_q;
    assign frame_valid_o = valid_q;
    assign frame_start_o = start_q;
    assign frame_last_o  = last_q;
    assign frame_idx_o   = idx_out_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign trig_lost_o   = lost_q;

`ifdef FRAME_SEQ_TRIG_LOST_CNT_EN
    logic [15:0] lost_cnt_q;
    logic [15:0] lost_cnt_d;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Next count: one step per trig_lost_o pulse, held at full scale.
    always_comb begin
        lost_cnt_d = lost_cnt_q;
        if (lost_q) begin
            lost_cnt_d = sat_inc16(lost_cnt_q);
        end
    end

    // Count register; only reset clears it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lost_cnt_q <= '0;
        end else begin
            lost_cnt_q <= lost_cnt_d;
        end
    end

    assign trig_lost_cnt_o = lost_cnt_q;
`endif

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb_fft_frame_sequencer
// Directed scenarios with literal timing expectations followed by a long
// randomized run, all checked cycle by cycle against a timeline model of the
// sequencer kept in this bench.
module tb_fft_frame_sequencer;
    localparam int FL = 512;
    localparam int DW = 16;

    logic          clk_i        = 1'b0;
    logic          rst_i        = 1'b1;
    logic          trig_i       = 1'b0;
    logic [15:0]   cfg_delay_i  = '0;
    logic [7:0]    cfg_frames_i = '0;
    logic          fft_ready_i  = 1'b0;
    logic [DW-1:0] x0_i         = '0;
    logic [DW-1:0] x0z_i        = '0;
    logic [DW-1:0] y0_o;
    logic [DW-1:0] y0z_o;
    logic          frame_valid_o;
    logic          frame_start_o;
    logic          frame_last_o;
    logic [7:0]    frame_idx_o;
    logic          busy_o;
    logic          done_o;
    logic          trig_lost_o;
`ifdef FRAME_SEQ_TRIG_LOST_CNT_EN
    logic [15:0]   trig_lost_cnt_o;
`endif

    fft_frame_sequencer #(.FRAME_LEN(FL), .DW(DW)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .trig_i        (trig_i),
        .cfg_delay_i   (cfg_delay_i),
        .cfg_frames_i  (cfg_frames_i),
        .fft_ready_i   (fft_ready_i),
        .x0_i          (x0_i),
        .x0z_i         (x0z_i),
        .y0_o          (y0_o),
        .y0z_o         (y0z_o),
        .frame_valid_o (frame_valid_o),
        .frame_start_o (frame_start_o),
        .frame_last_o  (frame_last_o),
        .frame_idx_o   (frame_idx_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
`ifdef FRAME_SEQ_TRIG_LOST_CNT_EN
        .trig_lost_o     (trig_lost_o),
        .trig_lost_cnt_o (trig_lost_cnt_o)
`else
        .trig_lost_o     (trig_lost_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT (cycle %0d)", name, cyc);
    endtask

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    // ---------------------------------------------------------------
    // Reference model: describes a sequence as a timeline (delay, wait
    // for ready, stream frames) and publishes the outputs expected
    // after each clock edge.
    // ---------------------------------------------------------------
    logic          s_rst, s_trig, s_ready;
    logic [7:0]    s_frames;
    logic [15:0]   s_delay;
    logic [DW-1:0] s_x0, s_x0z;
    bit            prev_trig = 1'b1;
    bit            in_seq    = 1'b0;
    bit            was_seq   = 1'b0;
    bit            was_done  = 1'b0;
    bit            edge_now  = 1'b0;
    bit            chk_en    = 1'b0;
    bit            e_valid = 1'b0, e_start = 1'b0, e_last = 1'b0;
    bit            e_done  = 1'b0, e_busy  = 1'b0, e_lost = 1'b0;
    logic [DW-1:0] e_y0  = '0;
    logic [DW-1:0] e_y0z = '0;
    int            e_idx = 0;
    int            e_cnt = 0;

    // Advance one clock: capture what the DUT sampled and set default expectations.
    task automatic tick();
        @(posedge clk_i);
        s_rst    = rst_i;
        s_trig   = trig_i;
        s_ready  = fft_ready_i;
        s_frames = cfg_frames_i;
        s_delay  = cfg_delay_i;
        s_x0     = x0_i;
        s_x0z    = x0z_i;
        was_seq  = in_seq;
        was_done = e_done;
        if (!s_rst && e_lost && e_cnt != 65535) e_cnt++;
        e_valid = 1'b0; e_start = 1'b0; e_last = 1'b0; e_done = 1'b0;
        e_y0 = '0; e_y0z = '0; e_idx = 0;
        if (s_rst) begin
            in_seq    = 1'b0;
            e_busy    = 1'b0;
            e_lost    = 1'b0;
            e_cnt     = 0;
            prev_trig = 1'b1;
            edge_now  = 1'b0;
            chk_en    = 1'b1;
        end else begin
            edge_now  = s_trig && !prev_trig;
            prev_trig = s_trig;
            e_busy    = was_seq;
            e_lost    = edge_now && (was_seq || was_done);
        end
    endtask

    // One accepted trigger; returns early if reset cuts it short.
    task automatic run_seq(input int dly, input int nfr);
        bit ready_at_end;
        ready_at_end = 1'b0;
        in_seq = 1'b1;
        for (int i = 0; i < dly + 1; i++) begin
            tick();
            if (s_rst) return;
        end
        for (int f = 0; f < nfr; f++) begin
            if (f == 0 || !ready_at_end) begin
                do begin
                    tick();
                    if (s_rst) return;
                end while (!s_ready);
            end
            for (int p = 0; p < FL; p++) begin
                tick();
                if (s_rst) return;
                e_valid = 1'b1;
                e_y0    = s_x0;
                e_y0z   = s_x0z;
                e_start = (p == 0);
                e_last  = (p == FL - 1);
                e_idx   = f;
                if (p == FL - 1) ready_at_end = s_ready;
            end
        end
        e_done = 1'b1;
        in_seq = 1'b0;
    endtask

    initial begin : model
        forever begin
            tick();
            if (!s_rst && edge_now && !was_seq && !was_done && s_frames != 8'd0)
                run_seq(int'(s_delay), int'(s_frames));
        end
    end

    // ---------------------------------------------------------------
    // Compare process and event observation (falling edge).
    // ---------------------------------------------------------------
    int obs_start_n, obs_last_n, obs_done_n, obs_lost_n, obs_valid_n, obs_busy_n;
    int obs_start_cyc[8];
    int obs_start_idx[8];
    int obs_last_cyc[8];
    int obs_done_cyc, obs_busy_fall;
    bit prev_busy;

    always @(negedge clk_i) begin
        if (chk_en) begin
            check("ctl{valid,start,last,done,busy,lost}",
                  64'({frame_valid_o, frame_start_o, frame_last_o, done_o, busy_o, trig_lost_o}),
                  64'({e_valid, e_start, e_last, e_done, e_busy, e_lost}));
            check("y0", 64'(y0_o), 64'(e_y0));
            check("y0z", 64'(y0z_o), 64'(e_y0z));
            if (e_valid) check("frame_idx", 64'(frame_idx_o), 64'(e_idx));
`ifdef FRAME_SEQ_TRIG_LOST_CNT_EN
            check("trig_lost_cnt", 64'(trig_lost_cnt_o), 64'(e_cnt));
`endif
        end
        if (frame_start_o === 1'b1) begin
            if (obs_start_n < 8) begin
                obs_start_cyc[obs_start_n] = cyc;
                obs_start_idx[obs_start_n] = int'(frame_idx_o);
            end
            obs_start_n++;
        end
        if (frame_last_o === 1'b1) begin
            if (obs_last_n < 8) obs_last_cyc[obs_last_n] = cyc;
            obs_last_n++;
        end
        if (done_o === 1'b1) begin
            obs_done_cyc = cyc;
            obs_done_n++;
        end
        if (trig_lost_o === 1'b1) obs_lost_n++;
        if (frame_valid_o === 1'b1) obs_valid_n++;
        if (busy_o === 1'b1) obs_busy_n++;
        if (prev_busy && busy_o === 1'b0) obs_busy_fall = cyc;
        prev_busy = (busy_o === 1'b1);
    end

    // ---------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------
    task automatic clear_obs();
        obs_start_n = 0; obs_last_n = 0; obs_done_n = 0; obs_lost_n = 0;
        obs_valid_n = 0; obs_busy_n = 0; obs_done_cyc = 0; obs_busy_fall = 0;
        for (int i = 0; i < 8; i++) begin
            obs_start_cyc[i] = 0; obs_start_idx[i] = 0; obs_last_cyc[i] = 0;
        end
    endtask

    task automatic cycle();
        @(posedge clk_i);
        #1;
        x0_i  = DW'($urandom);
        x0z_i = DW'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
    endtask

    task automatic pulse_trig(output int t);
        trig_i = 1'b1;
        t = cyc;
        cycle();
        trig_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n0;
        int k;
        n0 = obs_done_n;
        k  = 0;
        while (obs_done_n == n0 && k < budget) begin
            cycle();
            k++;
        end
        if (obs_done_n == n0) timeout(name);
    endtask

    task automatic wait_start(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (obs_start_n < n && k < budget) begin
            cycle();
            k++;
        end
        if (obs_start_n < n) timeout(name);
    endtask

    task automatic check_all_zero(input string name);
        @(negedge clk_i);
        check(name, 64'({y0_o, y0z_o, frame_valid_o, frame_start_o, frame_last_o,
                         frame_idx_o, busy_o, done_o, trig_lost_o}), 64'(0));
    endtask

    // ---------------------------------------------------------------
    // Test sequence
    // ---------------------------------------------------------------
    initial begin : stim
        int t;
        int s0;
        int r;
        clear_obs();
        cycle();
        cycle();
        rst_i = 1'b0;
        check_all_zero("reset_outputs");

        // Single frame, delay 3: literal timing; cfg changes after latch.
        cfg_delay_i = 16'd3; cfg_frames_i = 8'd1; fft_ready_i = 1'b1;
        idle(4);
        clear_obs();
        pulse_trig(t);
        cfg_delay_i = 16'd50; cfg_frames_i = 8'd5;
        wait_done(700, "single_frame_done");
        idle(3);
        check("single_start_cycle", 64'(obs_start_cyc[0]), 64'(t + 7));
        check("single_last_cycle", 64'(obs_last_cyc[0]), 64'(t + 518));
        check("single_done_cycle", 64'(obs_done_cyc), 64'(t + 518));
        check("single_busy_fall", 64'(obs_busy_fall), 64'(t + 519));
        check("single_frame_count", 64'(obs_start_n), 64'(1));

        // Three back-to-back frames with ready held high.
        do_reset();
        cfg_delay_i = 16'd5; cfg_frames_i = 8'd3; fft_ready_i = 1'b1;
        idle(2);
        clear_obs();
        pulse_trig(t);
        wait_done(2000, "three_frames_done");
        idle(3);
        check("three_start0", 64'(obs_start_cyc[0]), 64'(t + 9));
        check("three_frame_count", 64'(obs_start_n), 64'(3));
        check("three_idx_seq", 64'({obs_start_idx[0][7:0], obs_start_idx[1][7:0], obs_start_idx[2][7:0]}),
              64'(24'h00_01_02));
        check("three_gap01", 64'(obs_start_cyc[1] - obs_start_cyc[0]), 64'(FL));
        check("three_gap12", 64'(obs_start_cyc[2] - obs_start_cyc[1]), 64'(FL));
        check("three_valid_cycles", 64'(obs_valid_n), 64'(3 * FL));
        check("three_done_count", 64'(obs_done_n), 64'(1));

        // Ready drops late in frame 0, returns 20 cycles later.
        do_reset();
        cfg_delay_i = 16'd2; cfg_frames_i = 8'd2; fft_ready_i = 1'b1;
        idle(2);
        clear_obs();
        pulse_trig(t);
        wait_start(1, 100, "ready_gap_start0");
        s0 = obs_start_cyc[0];
        while (cyc < s0 + 500) cycle();
        fft_ready_i = 1'b0;
        repeat (20) cycle();
        fft_ready_i = 1'b1;
        r = cyc;
        wait_done(800, "ready_gap_done");
        idle(2);
        check("ready_gap_frame0_len", 64'(obs_last_cyc[0] - obs_start_cyc[0]), 64'(FL - 1));
        check("ready_gap_frame1_start", 64'(obs_start_cyc[1]), 64'(r + 2));
        check("ready_gap_valid_cycles", 64'(obs_valid_n), 64'(2 * FL));
        check("ready_gap_done_count", 64'(obs_done_n), 64'(1));

        // Extra triggers during DELAY and during STREAM are dropped.
        do_reset();
        cfg_delay_i = 16'd20; cfg_frames_i = 8'd1; fft_ready_i = 1'b1;
        idle(2);
        clear_obs();
        pulse_trig(t);
        idle(3);
        trig_i = 1'b1;
        cycle();
        trig_i = 1'b0;
        wait_start(1, 100, "lost_start");
        idle(50);
        trig_i = 1'b1;
        cycle();
        trig_i = 1'b0;
        wait_done(700, "lost_done");
        idle(3);
        check("lost_pulses", 64'(obs_lost_n), 64'(2));
        check("lost_start_cycle", 64'(obs_start_cyc[0]), 64'(t + 24));
        check("lost_done_cycle", 64'(obs_done_cyc), 64'(t + 535));
`ifdef FRAME_SEQ_TRIG_LOST_CNT_EN
        check("lost_count_reg", 64'(trig_lost_cnt_o), 64'(2));
`endif

        // Reset mid-frame with trigger held high.
        do_reset();
        cfg_delay_i = 16'd1; cfg_frames_i = 8'd2; fft_ready_i = 1'b1;
        idle(2);
        clear_obs();
        trig_i = 1'b1;
        cycle();
        wait_start(1, 100, "abort_start");
        idle(100);
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        clear_obs();
        check_all_zero("abort_outputs_zero");
        idle(60);
        check("abort_no_busy", 64'(obs_busy_n), 64'(0));
        check("abort_no_done", 64'(obs_done_n), 64'(0));
        check("abort_no_restart", 64'(obs_start_n), 64'(0));
        trig_i = 1'b0;
        cycle();
        clear_obs();
        pulse_trig(t);
        wait_start(1, 100, "abort_retrigger");
        check("abort_retrigger_start", 64'(obs_start_cyc[0]), 64'(t + 5));
        do_reset();

        // Zero frames ignores the trigger; zero delay gives minimum latency.
        cfg_delay_i = 16'd0; cfg_frames_i = 8'd0; fft_ready_i = 1'b1;
        idle(2);
        clear_obs();
        pulse_trig(t);
        idle(30);
        check("zero_frames_busy", 64'(obs_busy_n), 64'(0));
        check("zero_frames_lost", 64'(obs_lost_n), 64'(0));
        cfg_frames_i = 8'd1;
        clear_obs();
        pulse_trig(t);
        wait_start(1, 50, "zero_delay_start");
        check("zero_delay_start_cycle", 64'(obs_start_cyc[0]), 64'(t + 4));
        wait_done(700, "zero_delay_done");

        // Randomized traffic: triggers, ready, cfg churn and rare resets.
        do_reset();
        for (int i = 0; i < 40000; i++) begin
            if ($urandom_range(0, 99) == 0) trig_i = ~trig_i;
            if ($urandom_range(0, 59) == 0) fft_ready_i = ~fft_ready_i;
            cfg_frames_i = 8'($urandom_range(0, 3));
            cfg_delay_i  = 16'($urandom_range(0, 40));
            rst_i        = ($urandom_range(0, 7999) == 0);
            cycle();
        end
        rst_i = 1'b0;
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
